// File: rtl/bin_to_bcd8.sv
// Sequential binary-to-BCD converter (shift-add-3) driving eight display digits.
// Digit and overflow outputs update only on completion, so no partial value is ever visible.
module bin_to_bcd8 #(
  parameter int          BIN_W   = 27,
  parameter int unsigned MAX_VAL = 99_999_999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       uni,
  output logic [3:0]       ten,
  output logic [3:0]       hun,
  output logic [3:0]       tho,
  output logic [3:0]       tt,
  output logic [3:0]       ht,
  output logic [3:0]       mil,
  output logic [3:0]       tmil
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [31:0]      scratch;
  logic [31:0]      adj;
  logic [31:0]      dig;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic             over;

  // Overflow test on the raw input, zero-extended to 32 bits.
  assign over = (32'(bin) > 32'(MAX_VAL));
  assign busy = (state != IDLE);

  // Add-3 correction applied to all eight nibbles in parallel.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 8; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: overflowing inputs skip the shift phase entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = over ? FIN : SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift with correction, then atomic commit to the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sh   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      dig      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bin_sh   <= bin;
          scratch  <= '0;
          cnt      <= '0;
          ovf_pend <= over;
        end
        SHIFT: begin
          scratch <= {adj[30:0], bin_sh[BIN_W-1]};
          bin_sh  <= bin_sh << 1;
          cnt     <= cnt + 1'b1;
        end
        FIN: begin
          dig  <= ovf_pend ? 32'h9999_9999 : scratch;
          ovf  <= ovf_pend;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign uni  = dig[3:0];
  assign ten  = dig[7:4];
  assign hun  = dig[11:8];
  assign tho  = dig[15:12];
  assign tt   = dig[19:16];
  assign ht   = dig[23:20];
  assign mil  = dig[27:24];
  assign tmil = dig[31:28];

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Randomized self-checking bench for bin_to_bcd8 against a decimal-arithmetic reference.
module tb_bin_to_bcd8;

  localparam int          BIN_W   = 27;
  localparam int unsigned MAX_VAL = 99_999_999;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             busy, done, ovf;
  logic [3:0]       uni, ten, hun, tho, tt, ht, mil, tmil;

  int total = 0;
  int bad   = 0;

  bin_to_bcd8 #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf),
    .uni(uni), .ten(ten), .hun(hun), .tho(tho),
    .tt(tt), .ht(ht), .mil(mil), .tmil(tmil)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, all nines on overflow.
  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    if (v > MAX_VAL) return 32'h9999_9999;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] digs();
    return {tmil, mil, ht, tt, tho, hun, ten, uni};
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one conversion from a point just after a rising edge, optionally
  // poking a second start (with a different value) while busy, then check.
  task automatic run(input longint unsigned v, input int poke_at, input logic [BIN_W-1:0] poke_val);
    int lat;
    int exp_lat;
    logic busy_ok;
    exp_lat = (v > MAX_VAL) ? 1 : BIN_W + 1;
    start = 1'b1;
    bin   = BIN_W'(v);
    @(posedge clk); #1;
    start = 1'b0;
    bin   = BIN_W'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      start = (lat == poke_at);
      if (lat == poke_at) bin = poke_val;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk($sformatf("latency(%0d)", v), lat, exp_lat);
    chk($sformatf("busy_during(%0d)", v), busy_ok, 1);
    chk($sformatf("busy_at_done(%0d)", v), busy, 0);
    chk($sformatf("digits(%0d)", v), digs(), ref_bcd(v));
    chk($sformatf("ovf(%0d)", v), ovf, (v > MAX_VAL));
  endtask

  // Let the done cycle end and confirm the pulse was a single cycle.
  task automatic settle(input longint unsigned v);
    @(posedge clk); #1;
    chk($sformatf("done_pulse(%0d)", v), done, 0);
    chk($sformatf("hold(%0d)", v), digs(), ref_bcd(v));
  endtask

  initial begin
    longint unsigned v;
    int seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_digits", digs(), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run(0, -1, '0);            settle(0);
    run(12_345_678, -1, '0);   settle(12_345_678);
    run(99_999_999, -1, '0);   settle(99_999_999);
    run(100_000_000, -1, '0);  settle(100_000_000);
    run(305, 5, BIN_W'(7));    settle(305);
    run(134_217_727, -1, '0);  settle(134_217_727);

    // Start in the done cycle is accepted immediately.
    run(77, -1, '0);
    run(42, -1, '0);
    chk("b2b_ten", ten, 4);
    chk("b2b_uni", uni, 2);
    settle(42);

    // A valid conversion after an overflow clears ovf.
    run(100_000_001, -1, '0);
    run(1, -1, '0);
    settle(1);

    // Reset in the middle of a conversion abandons it.
    start = 1'b1; bin = BIN_W'(999);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_digits", digs(), 0);
    chk("midrst_ovf", ovf, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run(999, -1, '0); settle(999);

    // Randomized values, biased so both ranges and the boundary get traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 9999);
        1: v = $urandom_range(MAX_VAL - 5, MAX_VAL + 5);
        default: v = $urandom % (1 << BIN_W);
      endcase
      run(v, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1, BIN_W'($urandom));
      if ($urandom_range(0, 1) == 1) settle(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
